// File: rtl/mux_scan_nbit.sv
// mux_scan_nbit: registered CH-to-1 word mux with an enable-masked auto channel scanner
module mux_scan_nbit #(
  parameter int N = 4,
  parameter int CH = 8,
  parameter int SEL_W = 3,
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [CH-1:0] en,
  input  logic [CH*N-1:0] w,
  output logic [N-1:0] f,
  output logic [SEL_W-1:0] ch,
  output logic valid,
  output logic tick
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int NS = 1 << SEL_W;
  logic [CW-1:0] cnt, cnt_n;
  logic [NS-1:0] en_x;
  logic [NS*N-1:0] w_x;
  logic [SEL_W-1:0] nx, hi, lo, nch;
  logic hi_f, v_n;
  // widen mask and data to the full select range so out-of-range indices read as disabled zero
  always_comb begin
    en_x = '0;
    en_x[CH-1:0] = en;
    w_x = '0;
    w_x[CH*N-1:0] = w;
  end
  // single-cycle priority search: lowest enabled index above ch, else lowest enabled overall
  always_comb begin
    hi = '0;
    lo = '0;
    hi_f = 1'b0;
    for (int j = CH - 1; j >= 0; j--) begin
      if (en[j]) lo = SEL_W'(j);
      if (en[j] && j > int'(ch)) begin
        hi = SEL_W'(j);
        hi_f = 1'b1;
      end
    end
    nx = hi_f ? hi : lo;
  end
  // next channel and dwell count; a freshly presented channel starts its dwell at count 0
  always_comb begin
    nch = sel;
    cnt_n = '0;
    if (mode) begin
      nch = ch;
      if (en != '0 && !en_x[ch]) nch = nx;
      else if (en != '0 && valid) begin
        if (cnt == CW'(DIV - 1)) nch = nx;
        else cnt_n = cnt + CW'(1);
      end
    end
    v_n = en_x[nch];
  end
  // output and dwell registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f <= '0;
      ch <= '0;
      valid <= 1'b0;
      tick <= 1'b0;
      cnt <= '0;
    end else begin
      f <= v_n ? w_x[nch*N +: N] : '0;
      ch <= nch;
      valid <= v_n;
      tick <= nch != ch;
      cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_mux_scan_nbit.sv
// tb_mux_scan_nbit: directed plus randomized checks of four mux_scan_nbit configurations
module tb_mux_scan_nbit;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic mode = 1'b1;
  logic [2:0] sel = '0;
  logic [7:0] en = 8'hFF;
  logic [31:0] w = '0;
  logic [3:0] f_o [4];
  logic [2:0] ch_o [4];
  logic v_o [4];
  logic t_o [4];
  int checks = 0;
  int failures = 0;
  int div [4] = '{4, 2, 8, 3};
  int chn [4] = '{8, 8, 8, 5};
  int m_ch [4];
  int m_age [4];
  int n_ch [4];
  int n_age [4];
  logic m_v [4];
  logic m_t [4];
  logic [3:0] m_f [4];

  always #5 clk = ~clk;

  mux_scan_nbit #(.N(4), .CH(8), .SEL_W(3), .DIV(4)) d0 (.clk(clk), .reset_n(reset_n), .mode(mode), .sel(sel), .en(en), .w(w),
    .f(f_o[0]), .ch(ch_o[0]), .valid(v_o[0]), .tick(t_o[0]));
  mux_scan_nbit #(.N(4), .CH(8), .SEL_W(3), .DIV(2)) d1 (.clk(clk), .reset_n(reset_n), .mode(mode), .sel(sel), .en(en), .w(w),
    .f(f_o[1]), .ch(ch_o[1]), .valid(v_o[1]), .tick(t_o[1]));
  mux_scan_nbit #(.N(4), .CH(8), .SEL_W(3), .DIV(8)) d2 (.clk(clk), .reset_n(reset_n), .mode(mode), .sel(sel), .en(en), .w(w),
    .f(f_o[2]), .ch(ch_o[2]), .valid(v_o[2]), .tick(t_o[2]));
  mux_scan_nbit #(.N(4), .CH(5), .SEL_W(3), .DIV(3)) d3 (.clk(clk), .reset_n(reset_n), .mode(mode), .sel(sel), .en(en[4:0]), .w(w[19:0]),
    .f(f_o[3]), .ch(ch_o[3]), .valid(v_o[3]), .tick(t_o[3]));

  function automatic bit ok(int k, int c);
    return c < chn[k] && en[c];
  endfunction

  function automatic bit anyen(int k);
    for (int i = 0; i < chn[k]; i++) if (en[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int nxt(int k, int c);
    int q[$];
    for (int i = 0; i < chn[k]; i++) if (en[i]) q.push_back(i);
    foreach (q[i]) if (q[i] > c) return q[i];
    return q.size() > 0 ? q[0] : c;
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_ch[k] = 0;
      m_age[k] = 0;
      m_v[k] = 1'b0;
      m_t[k] = 1'b0;
      m_f[k] = '0;
    end
  endtask

  task automatic chk_all();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("d%0d.f", k), 32'(f_o[k]), 32'(m_f[k]));
      chk($sformatf("d%0d.ch", k), 32'(ch_o[k]), m_ch[k]);
      chk($sformatf("d%0d.valid", k), 32'(v_o[k]), 32'(m_v[k]));
      chk($sformatf("d%0d.tick", k), 32'(t_o[k]), 32'(m_t[k]));
    end
  endtask

  // age = number of cycles the current channel has been shown valid; step once it reaches DIV
  task automatic model_calc();
    for (int k = 0; k < 4; k++) begin
      int c = m_ch[k];
      int a = m_age[k];
      int n = c;
      if (!mode) begin
        n = int'(sel);
        a = ok(k, n) ? 1 : 0;
      end else if (!anyen(k)) a = 0;
      else if (!ok(k, c)) begin
        n = nxt(k, c);
        a = 1;
      end else if (a == 0) a = 1;
      else if (a >= div[k]) begin
        n = nxt(k, c);
        a = 1;
      end else a++;
      n_ch[k] = n;
      n_age[k] = a;
    end
  endtask

  task automatic cyc();
    model_calc();
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      m_t[k] = n_ch[k] != m_ch[k];
      m_ch[k] = n_ch[k];
      m_age[k] = n_age[k];
      m_v[k] = ok(k, n_ch[k]);
      m_f[k] = m_v[k] ? w[n_ch[k]*4 +: 4] : 4'd0;
    end
    chk_all();
  endtask

  initial begin
    int sk [8] = '{0, 2, 2, 5, 5, 7, 7, 0};
    int prev;
    int t;
    w = 32'h9ABC_DEF1;
    #2 reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all();
    chk("rst_f", 32'(f_o[0]), 0);
    chk("rst_valid", 32'(v_o[0]), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("post_rst_ch0", 32'(ch_o[0]), 0);
      chk("post_rst_valid", 32'(v_o[0]), 1);
    end
    cyc();
    chk("post_rst_ch1", 32'(ch_o[0]), 1);
    chk("post_rst_tick", 32'(t_o[0]), 1);

    mode = 1'b0;
    for (int k = 0; k < 8; k++) w[k*4 +: 4] = 4'(k + 3);
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      cyc();
      chk("man_f", 32'(f_o[0]), s + 3);
      chk("man_valid", 32'(v_o[0]), 1);
      if (s > 0) chk("man_tick", 32'(t_o[0]), 1);
      if (s == 2) chk("man_sel2", 32'(f_o[0]), 5);
      if (s == 6) begin
        chk("np2_f", 32'(f_o[3]), 0);
        chk("np2_valid", 32'(v_o[3]), 0);
        chk("np2_ch", 32'(ch_o[3]), 6);
      end
    end

    sel = 3'd0;
    cyc();
    mode = 1'b1;
    en = 8'hA5;
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("skip_ch", 32'(ch_o[1]), sk[i]);
      chk("skip_tick", 32'(t_o[1]), 32'(sk[i] != prev));
      prev = sk[i];
    end

    mode = 1'b0;
    en = 8'hFF;
    sel = 3'd3;
    cyc();
    mode = 1'b1;
    cyc();
    cyc();
    chk("dis_ch3", 32'(ch_o[2]), 3);
    en = 8'hF7;
    cyc();
    chk("dis_ch", 32'(ch_o[2]), 4);
    chk("dis_valid", 32'(v_o[2]), 1);
    chk("dis_tick", 32'(t_o[2]), 1);

    mode = 1'b0;
    sel = 3'd1;
    en = 8'hFF;
    cyc();
    mode = 1'b1;
    en = 8'h00;
    repeat (3) begin
      cyc();
      chk("empty_valid", 32'(v_o[0]), 0);
      chk("empty_f", 32'(f_o[0]), 0);
      chk("empty_tick", 32'(t_o[0]), 0);
      chk("empty_ch", 32'(ch_o[0]), 1);
    end
    en = 8'h10;
    cyc();
    chk("single_ch", 32'(ch_o[0]), 4);
    chk("single_valid", 32'(v_o[0]), 1);
    chk("single_tick", 32'(t_o[0]), 1);
    repeat (12) begin
      cyc();
      chk("single_hold_tick", 32'(t_o[0]), 0);
    end

    en = 8'hFF;
    mode = 1'b0;
    sel = 3'd6;
    cyc();
    mode = 1'b1;
    cyc();
    chk("np2_scan_from6", 32'(ch_o[3]), 0);
    t = 0;
    while (ch_o[3] != 3'd4 && t < 20) begin
      cyc();
      t++;
    end
    chk("wrap_reach4", 32'(ch_o[3]), 4);
    repeat (3) cyc();
    chk("wrap_to0", 32'(ch_o[3]), 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 7) == 0) sel = 3'($urandom);
      if ($urandom_range(0, 9) == 0) en = $urandom_range(0, 3) == 0 ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      if ($urandom_range(0, 3) == 0) w = $urandom;
      if (i == 200) begin
        reset_n = 1'b0;
        #1;
        model_reset();
        chk_all();
        reset_n = 1'b1;
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_scan_nbit.md
# mux_scan_nbit

Parametrised, registered CH-to-1 multiplexer of N-bit words with a built-in channel scanner. It is the next generation of the team's fixed 8x1 n-bit mux. It is generalised in channel count and adds a registered output and an auto-scan mode that steps through enabled channels at a programmable dwell rate. A per-channel enable mask lets the scan skip channels. Typical use is driving time-multiplexed displays and sampling several sources from one FSM datapath.

## Interface
- N, 4, data word width in bits (>=1)
- CH, 8, number of input channels (2..256)
- SEL_W, 3, select/channel index width; must equal clog2(CH)
- DIV, 4, dwell length in clock cycles per channel in scan mode (>=1)
- clk  input  1  system clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- mode  input  1  0 = manual select, 1 = auto scan
- sel  input  SEL_W  channel index used in manual mode
- en  input  CH  channel enable mask; bit k enables channel k in both modes
- w  input  CH*N  flattened data; channel k occupies w[k*N +: N]
- f  output  N  registered selected word
- ch  output  SEL_W  registered index of the channel currently driving f
- valid  output  1  registered; 1 when f carries an enabled, in-range channel
- tick  output  1  one-cycle pulse when ch changes value

## Operation
- Reset (reset_n low, asynchronous): f=0, ch=0, valid=0, tick=0, dwell counter=0. Outputs hold these values until the first rising clk edge after reset_n rises.
- Each cycle the block computes a next channel nch. Then f<=w[nch], ch<=nch, valid<=(nch<CH && en[nch]), tick<=(nch!=ch).
- If valid would be 0, f<=0.
- Manual mode: nch=sel and the dwell counter is held at 0.
  - sel>=CH (only possible when CH is not a power of 2): f=0, valid=0, ch=sel.
  - Disabled channel selected: f=0, valid=0.
- Scan mode, dwell counter runs 0..DIV-1:
  - Counter < DIV-1 and en[ch]=1: counter increments, nch=ch.
  - Counter = DIV-1: counter <= 0, nch = next enabled index after ch in ascending order, wrapping CH-1 -> 0.
  - If ch is the only enabled channel, nch=ch and tick stays 0.
- Scan mode with en[ch]=0 (channel disabled mid-dwell, or scan entered on a disabled channel): advance to the next enabled channel on the next edge regardless of the counter. Counter <= 0.
- Scan mode with en all zero: nch=ch (hold), counter held at 0, valid=0, f=0, tick=0.
- Data is live: while a channel dwells, f follows changes on that channel's w slice with 1-cycle latency.
- Mode change manual->scan: scanning starts from the current ch with the counter at 0.
- Mode change scan->manual: the next edge loads sel. The counter is cleared.
- The next-enabled search is a combinational priority search over CH bits. No multi-cycle search is allowed.

## Timing
- Latency: 1 clock from any input (sel, en, w, mode) change to f/ch/valid/tick.
- In scan mode with all channels enabled, each channel is presented for exactly DIV consecutive cycles. tick pulses on the first cycle of each new channel, i.e. every DIV cycles.
- DIV=1: the channel advances every cycle and tick is high continuously while more than one channel is enabled.
- Reset assertion mid-dwell clears the counter immediately. After release, the first scan step occurs DIV edges after the first active edge.
- No combinational path from inputs to outputs. All four outputs are flops.

## Test plan
- Reset: hold reset_n=0 with w nonzero, mode=1 -> f=0, ch=0, valid=0, tick=0. Release; with en=8'hFF, DIV=4, channel 0 is presented for 4 cycles, then ch=1 with a tick pulse.
- Manual select: N=4, CH=8, w slice k = k+3, en=8'hFF, step sel 0..7 -> one cycle later f=sel+3, valid=1, and tick=1 on each change.
  - Regression check: sel=2 must give f=5 (w2, not w3).
- Scan skip: en=8'b1010_0101, DIV=2 -> ch sequence 0,0,2,2,5,5,7,7,0, with tick on each index change only.
- Disable mid-dwell: DIV=8, scanning on ch=3, clear en[3] at dwell count 2 -> next edge ch=next enabled channel, counter=0, valid stays 1.
- Empty mask: en=0 in scan mode -> valid=0, f=0, ch frozen, no tick. Set en=8'h10 -> next edge ch=4, valid=1, tick=1, and no further ticks afterwards.
- Non-power-of-2: CH=5, SEL_W=3, manual sel=6 -> f=0, valid=0. In scan mode the wrap goes 4 -> 0.
